alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU (WIDTH-bit, 3-bit opcode, outputs alu_out and a_is_zero) between NREQ requesters.
- Each cycle it selects at most one valid requester using a round-robin scheme and drives that requester's opcode and operands onto the ALU.
- It registers the ALU result with the winner's ID into a single output slot, using a valid/ready handshake.
- It sits between the ALU and the client blocks that issue operations to it.

Parameters:
- WIDTH, 8, operand and result width; must match the ALU's WIDTH.
- NREQ, 4, number of requesters, 2..8.
- IDW, 3, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has an operation pending (bit i).
- req_ready  out  NREQ  one-hot or zero; requester i is accepted this cycle.
- req_opcode  in  3*NREQ  flattened; slice [3i+2:3i] belongs to requester i.
- req_a  in  WIDTH*NREQ  flattened operand A per requester.
- req_b  in  WIDTH*NREQ  flattened operand B per requester.
- alu_opcode  out  3  to ALU opcode.
- alu_in_a  out  WIDTH  to ALU in_a.
- alu_in_b  out  WIDTH  to ALU in_b.
- alu_out  in  WIDTH  from ALU result.
- alu_a_is_zero  in  1  from ALU a_is_zero.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  WIDTH  registered alu_out.
- rsp_zero  out  1  registered a_is_zero.
- issue_count  out  16  number of accepted operations; wraps at 16'hFFFF->0.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, issue_count=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has highest priority after reset.
- Reset is honoured mid-operation: a pending response is discarded and no acceptance happens on the reset edge.
- Slot state is two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_issue = EMPTY or (FULL and rsp_ready). The slot gives full-throughput pass-through: drain and refill can happen in the same cycle.
- Arbitration is combinational:
  - When can_issue=1, the winner g is the first i with req_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NREQ.
  - req_ready = one-hot(g). It is all-zero when can_issue=0 or no req_valid bit is set.
  - req_ready never depends on rsp_data; a requester may deassert req_valid at any time without penalty.
- ALU drive:
  - While a grant exists, alu_opcode/alu_in_a/alu_in_b = the winner's slices.
  - Otherwise they are driven to 0, a deterministic value with no X propagation.
- On the clock edge where a grant exists:
  - rsp_data<=alu_out, rsp_zero<=alu_a_is_zero, rsp_id<=g, rsp_valid<=1.
  - last_grant<=g; issue_count<=issue_count+1.
  - Latency is 1 clock from acceptance to rsp_valid.
- On an edge with rsp_ready=1, FULL and no grant: rsp_valid<=0. The other response fields hold their last values.
- When FULL and rsp_ready=0: no grant is issued, the response holds stable, and last_grant is unchanged.
- rsp_ready while EMPTY is ignored.
- Fairness: with all NREQ valid continuously and rsp_ready=1, the grant order is 0,1,...,NREQ-1,0,... and no requester waits more than NREQ-1 grants.
- A single requester that is valid every cycle is granted every cycle.
- Opcode values are not interpreted by the arbiter; all 8 codes pass through unchanged.
- Slices and IDs for i>=NREQ do not exist; rsp_id values >= NREQ never occur.

Test Plan:
1. Reset, then req_valid=0001, op0=ADD(2), a0=8'h42, b0=8'h86, rsp_ready=1 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'hC8, rsp_zero=0, issue_count=1.
2. All four valid; per-requester ops: AND 42/86, XOR 42/86, PASSB 42/86, PASS7 00/86; rsp_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; responses are 02, C4, 86, 00 with rsp_zero=1 on the last; issue_count=4.
3. rsp_ready=0 with the slot FULL and requests 1 and 2 valid -> req_ready=0 and the response is stable for 5 cycles. Then raise rsp_ready -> the same cycle grants requester 1 (after last_grant=0), and the slot refills with no bubble.
4. Requester 3 valid continuously while others toggle -> requester 3 is granted at least once every 4 accepted grants.
5. Assert rst_n=0 asynchronously mid-cycle while FULL -> rsp_valid drops immediately, issue_count=0, and the next grant goes to the lowest valid index.
6. Preload issue_count near 16'hFFFF by 65535 accepts (or force) -> the next accept wraps it to 0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one external combinational ALU between NREQ requesters. Each cycle
// at most one valid requester is picked round-robin (searching upward from
// the requester after the previous winner), its opcode/operands are driven
// onto the ALU, and the ALU result is captured together with the winner's ID
// into a single-entry response slot guarded by a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[NREQ]   per-requester operation pending
//   req_ready[NREQ]   one-hot (or zero) acceptance, combinational
//   req_opcode        flattened 3-bit opcodes, slice [3i+2:3i] = requester i
//   req_a, req_b      flattened WIDTH-bit operands per requester
//   alu_opcode/alu_in_a/alu_in_b   drive to the ALU (zero when no grant)
//   alu_out, alu_a_is_zero         result from the ALU
//   rsp_valid/rsp_ready            response slot handshake
//   rsp_id, rsp_data, rsp_zero     registered winner ID, result, zero flag
//   issue_count       16-bit count of accepted operations, wraps to 0
// ---------------------------------------------------------------------------
module alu_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [3*NREQ-1:0]     req_opcode,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic [2:0]            alu_opcode,
   output logic [WIDTH-1:0]      alu_in_a,
   output logic [WIDTH-1:0]      alu_in_b,
   input  logic [WIDTH-1:0]      alu_out,
   input  logic                  alu_a_is_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_zero,
   output logic [15:0]           issue_count
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           state_reg;
   logic [IDW-1:0]   last_grant_reg;
   logic [IDW-1:0]   rsp_id_reg;
   logic [WIDTH-1:0] rsp_data_reg;
   logic             rsp_zero_reg;
   logic [15:0]      issue_count_reg;

   logic             can_issue;
   logic             grant_any;
   logic [NREQ-1:0]  hi_mask;
   logic [NREQ-1:0]  hi_req;
   logic [NREQ-1:0]  pick_hi;
   logic [NREQ-1:0]  pick_all;
   logic [NREQ-1:0]  grant_onehot;

   // AND-OR chains: entry NREQ holds the selected value, zero when no grant.
   logic [IDW-1:0]   idx_chain [NREQ+1];
   logic [2:0]       op_chain  [NREQ+1];
   logic [WIDTH-1:0] a_chain   [NREQ+1];
   logic [WIDTH-1:0] b_chain   [NREQ+1];

   // The slot can accept when empty or when it is being drained this cycle.
   assign can_issue = (state_reg == S_EMPTY) || rsp_ready;

   assign idx_chain[0] = '0;
   assign op_chain[0]  = '0;
   assign a_chain[0]   = '0;
   assign b_chain[0]   = '0;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         // Requesters strictly above the last winner get first chance.
         assign hi_mask[gi]      = (IDW'(gi) > last_grant_reg);
         assign idx_chain[gi+1]  = idx_chain[gi] | (grant_onehot[gi] ? IDW'(gi) : '0);
         assign op_chain[gi+1]   = op_chain[gi] | ({3{grant_onehot[gi]}} & req_opcode[3*gi +: 3]);
         assign a_chain[gi+1]    = a_chain[gi] | ({WIDTH{grant_onehot[gi]}} & req_a[WIDTH*gi +: WIDTH]);
         assign b_chain[gi+1]    = b_chain[gi] | ({WIDTH{grant_onehot[gi]}} & req_b[WIDTH*gi +: WIDTH]);
      end
   endgenerate

   // Lowest set bit of the upper window; if that window is empty the search
   // has wrapped, so take the lowest set bit overall.
   assign hi_req   = req_valid & hi_mask;
   assign pick_hi  = hi_req & (~hi_req + NREQ'(1));
   assign pick_all = req_valid & (~req_valid + NREQ'(1));

   assign grant_onehot = can_issue ? ((|hi_req) ? pick_hi : pick_all) : '0;
   assign grant_any    = |grant_onehot;

   assign req_ready   = grant_onehot;
   assign alu_opcode  = op_chain[NREQ];
   assign alu_in_a    = a_chain[NREQ];
   assign alu_in_b    = b_chain[NREQ];

   assign rsp_valid   = (state_reg == S_FULL);
   assign rsp_id      = rsp_id_reg;
   assign rsp_data    = rsp_data_reg;
   assign rsp_zero    = rsp_zero_reg;
   assign issue_count = issue_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_EMPTY;
         last_grant_reg  <= IDW'(NREQ - 1);
         rsp_id_reg      <= '0;
         rsp_data_reg    <= '0;
         rsp_zero_reg    <= 1'b0;
         issue_count_reg <= '0;
      end else begin
         if (grant_any) begin
            // Refill (possibly in the same cycle as a drain).
            state_reg       <= S_FULL;
            rsp_data_reg    <= alu_out;
            rsp_zero_reg    <= alu_a_is_zero;
            rsp_id_reg      <= idx_chain[NREQ];
            last_grant_reg  <= idx_chain[NREQ];
            issue_count_reg <= issue_count_reg + 16'd1;
         end else if ((state_reg == S_FULL) && rsp_ready) begin
            // Drain only; payload fields keep their last values.
            state_reg <= S_EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 3;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [3*NREQ-1:0]     req_opcode;
   logic [WIDTH*NREQ-1:0] req_a;
   logic [WIDTH*NREQ-1:0] req_b;
   logic [2:0]            alu_opcode;
   logic [WIDTH-1:0]      alu_in_a;
   logic [WIDTH-1:0]      alu_in_b;
   logic [WIDTH-1:0]      alu_out;
   logic                  alu_a_is_zero;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_zero;
   logic [15:0]           issue_count;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Per-requester operation table, packed onto the flat buses.
   logic [2:0]       op_v [NREQ];
   logic [WIDTH-1:0] a_v  [NREQ];
   logic [WIDTH-1:0] b_v  [NREQ];

   // Reference model state.
   int               m_last;
   bit               m_full;
   int               m_id;
   logic [WIDTH-1:0] m_data;
   bit               m_zero;
   logic [15:0]      m_count;
   int               m_win;
   logic [NREQ-1:0]  exp_ready;
   logic [2:0]       exp_op;
   logic [WIDTH-1:0] exp_a;
   logic [WIDTH-1:0] exp_b;
   bit               quiet;

   alu_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_opcode    (req_opcode),
      .req_a         (req_a),
      .req_b         (req_b),
      .alu_opcode    (alu_opcode),
      .alu_in_a      (alu_in_a),
      .alu_in_b      (alu_in_b),
      .alu_out       (alu_out),
      .alu_a_is_zero (alu_a_is_zero),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .rsp_zero      (rsp_zero),
      .issue_count   (issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: 0 AND, 1 XOR, 2 ADD, 3 PASSB, 4 SUB, 5 OR, 6 NOTA, 7 PASSA.
   function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a ^ b;
         3'd2:    return a + b;
         3'd3:    return b;
         3'd4:    return a - b;
         3'd5:    return a | b;
         3'd6:    return ~a;
         default: return a;
      endcase
   endfunction

   assign alu_out       = alu_f(alu_opcode, alu_in_a, alu_in_b);
   assign alu_a_is_zero = (alu_in_a == '0);

   always_comb begin
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_opcode[3*i +: 3]     = op_v[i];
         req_a[WIDTH*i +: WIDTH]  = a_v[i];
         req_b[WIDTH*i +: WIDTH]  = b_v[i];
      end
   end

   task automatic model_reset();
      m_last  = NREQ - 1;
      m_full  = 0;
      m_id    = 0;
      m_data  = '0;
      m_zero  = 0;
      m_count = '0;
      m_win   = -1;
   endtask

   // Apply inputs and predict this cycle's grant from the round-robin rule.
   task automatic drive(input logic [NREQ-1:0] v, input logic rr);
      int idx;
      req_valid = v;
      rsp_ready = rr;
      m_win = -1;
      if (!m_full || rr) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (m_win < 0 && v[idx]) m_win = idx;
         end
      end
      exp_ready = (m_win >= 0) ? (NREQ'(1) << m_win) : '0;
      exp_op    = (m_win >= 0) ? op_v[m_win] : 3'd0;
      exp_a     = (m_win >= 0) ? a_v[m_win]  : '0;
      exp_b     = (m_win >= 0) ? b_v[m_win]  : '0;
   endtask

   // Advance one clock and update the model with what the edge should do.
   task automatic tick();
      @(posedge clk);
      #1;
      if (m_win >= 0) begin
         m_full  = 1;
         m_id    = m_win;
         m_data  = alu_f(op_v[m_win], a_v[m_win], b_v[m_win]);
         m_zero  = (a_v[m_win] == '0);
         m_last  = m_win;
         m_count = m_count + 16'd1;
         if (!quiet)
            $display("txn: grant id=%0d op=%0d a=%02h b=%02h -> data=%02h zero=%0d count=%0d",
                     m_win, op_v[m_win], a_v[m_win], b_v[m_win], m_data, m_zero, m_count);
      end else if (m_full && rsp_ready) begin
         m_full = 0;
      end
      m_win = -1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         op_v[i] = 3'($urandom_range(0, 7));
         a_v[i]  = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
         b_v[i]  = WIDTH'($urandom);
      end
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zero, issue_count} !== '0)
         $display("FAIL reset_outputs: got valid=%0b id=%0d data=%02h zero=%0b count=%0d, want all 0",
                  rsp_valid, rsp_id, rsp_data, rsp_zero, issue_count);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      drive(4'b1111, 1'b1);
      #3;
      chk_cnt++;
      if (req_ready !== 4'b0001)
         $display("FAIL reset_priority: req_ready=%b want 0001", req_ready);
      else pass_cnt++;
      req_valid = '0;
      m_win = -1;
      tick();
   endtask

   task automatic test_single_add();
      reset_dut();
      op_v[0] = 3'd2; a_v[0] = 8'h42; b_v[0] = 8'h86;
      drive(4'b0001, 1'b1);
      #3;
      chk_cnt++;
      if (req_ready !== 4'b0001 || alu_opcode !== 3'd2 || alu_in_a !== 8'h42 || alu_in_b !== 8'h86)
         $display("FAIL add_grant: ready=%b op=%0d a=%02h b=%02h want 0001/2/42/86",
                  req_ready, alu_opcode, alu_in_a, alu_in_b);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== 8'hC8 || rsp_zero !== 1'b0 || issue_count !== 16'd1)
         $display("FAIL add_rsp: valid=%0b id=%0d data=%02h zero=%0b count=%0d want 1/0/C8/0/1",
                  rsp_valid, rsp_id, rsp_data, rsp_zero, issue_count);
      else pass_cnt++;
      drive(4'b0000, 1'b1);
      tick();
      chk_cnt++;
      if (rsp_valid !== 1'b0 || rsp_data !== 8'hC8)
         $display("FAIL add_drain: valid=%0b data=%02h want 0/C8", rsp_valid, rsp_data);
      else pass_cnt++;
   endtask

   task automatic test_rotation();
      logic [WIDTH-1:0] want [NREQ];
      want[0] = 8'h02; want[1] = 8'hC4; want[2] = 8'h86; want[3] = 8'h00;
      reset_dut();
      op_v[0] = 3'd0; a_v[0] = 8'h42; b_v[0] = 8'h86;
      op_v[1] = 3'd1; a_v[1] = 8'h42; b_v[1] = 8'h86;
      op_v[2] = 3'd3; a_v[2] = 8'h42; b_v[2] = 8'h86;
      op_v[3] = 3'd7; a_v[3] = 8'h00; b_v[3] = 8'h86;
      for (int k = 0; k < NREQ; k++) begin
         drive(4'b1111, 1'b1);
         #3;
         chk_cnt++;
         if (req_ready !== (NREQ'(1) << k))
            $display("FAIL rot_ready%0d: req_ready=%b want %b", k, req_ready, NREQ'(1) << k);
         else pass_cnt++;
         tick();
         chk_cnt++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(k) || rsp_data !== want[k] || rsp_zero !== (k == 3))
            $display("FAIL rot_rsp%0d: valid=%0b id=%0d data=%02h zero=%0b want 1/%0d/%02h/%0b",
                     k, rsp_valid, rsp_id, rsp_data, rsp_zero, k, want[k], k == 3);
         else pass_cnt++;
      end
      chk_cnt++;
      if (issue_count !== 16'd4)
         $display("FAIL rot_count: issue_count=%0d want 4", issue_count);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] held;
      reset_dut();
      rand_ops();
      drive(4'b0001, 1'b1);
      tick();
      held = m_data;
      for (int c = 0; c < 5; c++) begin
         drive(4'b0110, 1'b0);
         #3;
         chk_cnt++;
         if (req_ready !== 4'b0000)
            $display("FAIL bp_ready%0d: req_ready=%b want 0000", c, req_ready);
         else pass_cnt++;
         tick();
         chk_cnt++;
         if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== held || issue_count !== 16'd1)
            $display("FAIL bp_hold%0d: valid=%0b id=%0d data=%02h count=%0d want 1/0/%02h/1",
                     c, rsp_valid, rsp_id, rsp_data, issue_count, held);
         else pass_cnt++;
      end
      drive(4'b0110, 1'b1);
      #3;
      chk_cnt++;
      if (req_ready !== 4'b0010)
         $display("FAIL bp_release: req_ready=%b want 0010", req_ready);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_data !== m_data)
         $display("FAIL bp_refill: valid=%0b id=%0d data=%02h want 1/1/%02h",
                  rsp_valid, rsp_id, rsp_data, m_data);
      else pass_cnt++;
   endtask

   task automatic test_random(input int cycles, input bit force3);
      logic [NREQ-1:0] v;
      logic            rr;
      int              gap;
      gap = 0;
      reset_dut();
      for (int c = 0; c < cycles; c++) begin
         rand_ops();
         v  = NREQ'($urandom);
         if (force3) v[NREQ-1] = 1'b1;
         rr = ($urandom_range(0, 3) != 0);
         drive(v, rr);
         #3;
         chk_cnt++;
         if (req_ready !== exp_ready || alu_opcode !== exp_op || alu_in_a !== exp_a || alu_in_b !== exp_b)
            $display("FAIL rnd_grant c=%0d: ready=%b op=%0d a=%02h b=%02h want %b/%0d/%02h/%02h",
                     c, req_ready, alu_opcode, alu_in_a, alu_in_b, exp_ready, exp_op, exp_a, exp_b);
         else pass_cnt++;
         if (force3 && m_win >= 0) begin
            gap = (m_win == NREQ - 1) ? 0 : gap + 1;
            chk_cnt++;
            if (gap > NREQ - 1)
               $display("FAIL fair_gap c=%0d: %0d grants without requester 3, want <= %0d", c, gap, NREQ - 1);
            else pass_cnt++;
         end
         tick();
         chk_cnt++;
         if (rsp_valid !== m_full || rsp_id !== IDW'(m_id) || rsp_data !== m_data ||
             rsp_zero !== m_zero || issue_count !== m_count)
            $display("FAIL rnd_rsp c=%0d: valid=%0b id=%0d data=%02h zero=%0b count=%0d want %0b/%0d/%02h/%0b/%0d",
                     c, rsp_valid, rsp_id, rsp_data, rsp_zero, issue_count,
                     m_full, m_id, m_data, m_zero, m_count);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      rand_ops();
      drive(4'b0100, 1'b1);
      tick();
      drive(4'b1010, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_cnt++;
      if (rsp_valid !== 1'b0 || issue_count !== 16'd0 || rsp_id !== 3'd0 || rsp_data !== 8'h00)
         $display("FAIL arst_immediate: valid=%0b count=%0d id=%0d data=%02h want 0/0/0/00",
                  rsp_valid, issue_count, rsp_id, rsp_data);
      else pass_cnt++;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (rsp_valid !== 1'b0 || issue_count !== 16'd0)
         $display("FAIL arst_edge: valid=%0b count=%0d want 0/0", rsp_valid, issue_count);
      else pass_cnt++;
      #2;
      rst_n = 1'b1;
      #1;
      drive(4'b1010, 1'b1);
      #1;
      chk_cnt++;
      if (req_ready !== 4'b0010)
         $display("FAIL arst_lowest: req_ready=%b want 0010", req_ready);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || issue_count !== 16'd1)
         $display("FAIL arst_grant: valid=%0b id=%0d count=%0d want 1/1/1", rsp_valid, rsp_id, issue_count);
      else pass_cnt++;
   endtask

   task automatic test_count_wrap();
      reset_dut();
      op_v[2] = 3'd2; a_v[2] = 8'h01; b_v[2] = 8'h02;
      quiet = 1;
      for (int c = 0; c < 65535; c++) begin
         drive(4'b0100, 1'b1);
         tick();
      end
      quiet = 0;
      chk_cnt++;
      if (issue_count !== 16'hFFFF || rsp_valid !== 1'b1 || rsp_id !== 3'd2)
         $display("FAIL wrap_pre: count=%04h valid=%0b id=%0d want FFFF/1/2", issue_count, rsp_valid, rsp_id);
      else pass_cnt++;
      drive(4'b0100, 1'b1);
      tick();
      chk_cnt++;
      if (issue_count !== 16'h0000 || rsp_data !== 8'h03)
         $display("FAIL wrap_post: count=%04h data=%02h want 0000/03", issue_count, rsp_data);
      else pass_cnt++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet = 0;
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         op_v[i] = '0; a_v[i] = '0; b_v[i] = '0;
      end
      model_reset();
      test_reset();
      test_single_add();
      test_rotation();
      test_backpressure();
      test_random(60, 1'b1);
      test_random(200, 1'b0);
      test_async_reset();
      test_count_wrap();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
